// File: rtl/dmem_responder_if.sv
// Data-memory strobe/response bundle between the core (master) and the responder (slave).
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (output memread, memwrite, addr, wdata,
                    input  rdata, ready, busy, err);
    modport slave  (input  memread, memwrite, addr, wdata,
                    output rdata, ready, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory that answers memread/memwrite after WAIT_CYCLES wait states
// with a one-cycle ready pulse; requests are latched at acceptance.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            rd_q;
    logic            wr_q;
    logic            misalign_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic err_cond;
    logic exec;
    assign err_cond = misalign_q | (rd_q & wr_q);
    assign exec     = (state == S_WAIT) && (cnt == 4'd0);

    // Upper address bits wrap; they are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:AW+2];

    // Memory is never cleared; reset only blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && exec && wr_q && !err_cond)
            mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            misalign_q <= 1'b0;
            bus.ready  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.memread | bus.memwrite) begin
                        idx_q      <= bus.addr[AW+1:2];
                        misalign_q <= |bus.addr[1:0];
                        wdata_q    <= bus.wdata;
                        rd_q       <= bus.memread;
                        wr_q       <= bus.memwrite;
                        cnt        <= 4'(WAIT_CYCLES);
                        bus.busy   <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        bus.ready <= 1'b1;
                        bus.err   <= err_cond;
                        bus.rdata <= (!err_cond && rd_q) ? mem[idx_q] : 32'd0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with none, sharing clk/reset.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full access on the 2-wait-state unit: ready must appear on exactly the lat-th edge.
    task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd, input string tag);
        bus.memread = r; bus.memwrite = w; bus.addr = a; bus.wdata = d;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk({tag, " ready"}, 32'(bus.ready), 32'(k == 4));
        end
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " err"}, 32'(bus.err), 32'(e_err));
        chk({tag, " rdata"}, bus.rdata, e_rd);
        tick();
        chk({tag, " ready end"}, 32'(bus.ready), 32'd0);
        chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
        chk({tag, " rdata hold"}, bus.rdata, e_rd);
    endtask

    initial begin
        reset = 1'b1;
        bus.memread = 1'b0;  bus.memwrite = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.memread = 1'b0; bus0.memwrite = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle ready", 32'(bus.ready), 32'd0);
            chk("idle busy", 32'(bus.busy), 32'd0);
            chk("idle err", 32'(bus.err), 32'd0);
            chk("idle rdata", bus.rdata, 32'd0);
        end

        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, "wr10");
        xact(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10");

        xact(1'b0, 1'b1, 32'h20, 32'h5, 1'b0, 32'd0, "wr20");
        xact(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'd0, "misalign");
        xact(1'b1, 1'b1, 32'h20, 32'h99, 1'b1, 32'd0, "rdwr");
        xact(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5, "rd20");

        xact(1'b0, 1'b1, 32'h100, 32'h11111111, 1'b0, 32'd0, "wr100");
        xact(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, 32'h11111111, "wrap");

        // Master abandons the strobe right after acceptance; latched request must finish.
        bus.memwrite = 1'b1; bus.addr = 32'h30; bus.wdata = 32'hA5A5A5A5;
        tick();
        bus.memwrite = 1'b0; bus.addr = 32'h34; bus.wdata = 32'h0;
        pulses = 0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            if (bus.ready) pulses++;
            chk("drop ready", 32'(bus.ready), 32'(k == 4));
        end
        chk("drop pulses", 32'(pulses), 32'd1);
        xact(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A5A5A5, "drop rd");

        // Reset during WAIT must discard the write and suppress ready.
        xact(1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0, 32'd0, "wr8");
        bus.memwrite = 1'b1; bus.addr = 32'h8; bus.wdata = 32'hCAFE0000;
        tick();
        bus.memwrite = 1'b0;
        tick();
        chk("rst busy pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst rdata", bus.rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst no ready", 32'(bus.ready), 32'd0);
        end
        xact(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h12345678, "rd8 after rst");

        // Zero wait states: preload, then a read held high across three accesses.
        bus0.memwrite = 1'b1; bus0.addr = 32'h40; bus0.wdata = 32'h77;
        tick();
        chk("w0 wr ready1", 32'(bus0.ready), 32'd0);
        tick();
        chk("w0 wr ready2", 32'(bus0.ready), 32'd1);
        bus0.memwrite = 1'b0;
        tick();
        bus0.memread = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("w0 ready", 32'(bus0.ready), 32'((k % 3) == 2));
            chk("w0 busy", 32'(bus0.busy), 32'((k % 3) != 0));
        end
        bus0.memread = 1'b0;
        chk("w0 rdata", bus0.rdata, 32'h77);
        chk("w0 err", 32'(bus0.err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
